// File: rtl/ninjakun_hsctl.sv
// Hiscore save/restore controller for Ninja-Kun CPU0 work RAM.
// Pauses CPU0, validates the hiscore window, then copies bytes RAM<->buffer.
module ninjakun_hsctl #(
    parameter logic [15:0] HS_BASE = 16'hE000,
    parameter logic [7:0]  HS_LEN  = 8'd64,
    parameter logic [7:0]  CHK_S   = 8'h00,
    parameter logic [7:0]  CHK_E   = 8'h00,
    parameter logic [7:0]  TMO     = 8'd240
) (
    input  logic        CLK24M,
    input  logic        RESET_N,
    input  logic        VBLK,
    input  logic        RESTORE_REQ,
    input  logic        DUMP_REQ,
    output logic [15:0] HS_ADR,
    output logic [7:0]  HS_DIN,
    output logic        HS_WR,
    output logic        HS_ACC,
    input  logic [7:0]  HS_DOUT,
    output logic [7:0]  BUF_AD,
    output logic [7:0]  BUF_WD,
    output logic        BUF_WE,
    input  logic [7:0]  BUF_RD,
    output logic        PAUSE_REQ,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    typedef enum logic [3:0] {
        IDLE, WAITV, CK_ACC, CK_S, CK_E,
        CK_CMP, X_ACC, X_RD, X_WR, FIN
    } state_t;

    localparam logic [15:0] END_ADR = HS_BASE + {8'h00, HS_LEN} - 16'd1;
    localparam logic [7:0]  LAST    = HS_LEN - 8'd1;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [7:0]  sbyte_q, sbyte_d;
    logic        err_q, err_d;
    logic        rest_q, rest_d;
    logic        vblk_q;
    logic [15:0] hs_idx;

    assign hs_idx = HS_BASE + {8'h00, idx_q};
    assign ERR    = err_q;

    // State and datapath registers; VBLK history kept every cycle.
    always_ff @(posedge CLK24M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fcnt_q  <= '0;
            sbyte_q <= '0;
            err_q   <= 1'b0;
            rest_q  <= 1'b0;
            vblk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            sbyte_q <= sbyte_d;
            err_q   <= err_d;
            rest_q  <= rest_d;
            vblk_q  <= VBLK;
        end
    end

    // Next-state and Moore-style outputs decoded from the current state.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fcnt_d    = fcnt_q;
        sbyte_d   = sbyte_q;
        err_d     = err_q;
        rest_d    = rest_q;
        HS_ADR    = '0;
        HS_DIN    = '0;
        HS_WR     = 1'b0;
        HS_ACC    = 1'b0;
        BUF_AD    = '0;
        BUF_WD    = '0;
        BUF_WE    = 1'b0;
        PAUSE_REQ = 1'b0;
        BUSY      = (state_q != IDLE);
        DONE      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RESTORE_REQ) begin
                    state_d = WAITV;
                    err_d   = 1'b0;
                    fcnt_d  = '0;
                    rest_d  = 1'b1;
                end else if (DUMP_REQ) begin
                    state_d = X_ACC;
                    err_d   = 1'b0;
                    rest_d  = 1'b0;
                end
            end
            WAITV: begin
                if (fcnt_q == TMO) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if (VBLK && !vblk_q) begin
                    fcnt_d  = fcnt_q + 8'd1;
                    state_d = CK_ACC;
                end
            end
            CK_ACC: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                state_d   = CK_S;
            end
            CK_S: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                HS_ADR    = HS_BASE;
                state_d   = CK_E;
            end
            CK_E: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                HS_ADR    = END_ADR;
                sbyte_d   = HS_DOUT;
                state_d   = CK_CMP;
            end
            CK_CMP: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                if (sbyte_q == CHK_S && HS_DOUT == CHK_E)
                    state_d = X_ACC;
                else
                    state_d = WAITV;
            end
            X_ACC: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                idx_d     = '0;
                state_d   = X_RD;
            end
            X_RD: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                if (rest_q)
                    BUF_AD = idx_q;
                else
                    HS_ADR = hs_idx;
                state_d = X_WR;
            end
            X_WR: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                HS_ADR    = hs_idx;
                BUF_AD    = idx_q;
                if (rest_q) begin
                    HS_DIN = BUF_RD;
                    HS_WR  = 1'b1;
                end else begin
                    BUF_WD = HS_DOUT;
                    BUF_WE = 1'b1;
                end
                if (idx_q == LAST) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = X_RD;
                end
            end
            FIN: begin
                PAUSE_REQ = 1'b1;
                HS_ACC    = 1'b1;
                DONE      = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ninjakun_hsctl.sv
// Scoreboard bench for ninjakun_hsctl with behavioural RAM and host buffer.
// Expected writes are queued at stimulus time and drained after DONE.
module tb_ninjakun_hsctl;

    logic        clk = 1'b0;
    logic        rst_n, vblk, rreq, dreq;
    logic [15:0] hs_adr;
    logic [7:0]  hs_din, hs_dout, buf_ad, buf_wd, buf_rd;
    logic        hs_wr, hs_acc, buf_we, pause, busy, done, err;

    logic [7:0]  ram [0:65535];
    logic [7:0]  bufm [0:255];
    logic        bd_rwe, bd_bwe;
    logic [15:0] bd_radr;
    logic [7:0]  bd_rdat, bd_badr, bd_bdat;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int we_cnt = 0;
    int viol = 0;
    int done_cnt = 0;
    logic [23:0] exp_q [$];
    logic [23:0] obs_hs [$];
    logic [23:0] obs_buf [$];

    always #5 clk = ~clk;

    ninjakun_hsctl dut (
        .CLK24M(clk), .RESET_N(rst_n), .VBLK(vblk),
        .RESTORE_REQ(rreq), .DUMP_REQ(dreq),
        .HS_ADR(hs_adr), .HS_DIN(hs_din), .HS_WR(hs_wr),
        .HS_ACC(hs_acc), .HS_DOUT(hs_dout),
        .BUF_AD(buf_ad), .BUF_WD(buf_wd), .BUF_WE(buf_we),
        .BUF_RD(buf_rd), .PAUSE_REQ(pause), .BUSY(busy),
        .DONE(done), .ERR(err)
    );

    always @(posedge clk) begin
        if (hs_wr) ram[hs_adr] <= hs_din;
        else if (bd_rwe) ram[bd_radr] <= bd_rdat;
        hs_dout <= ram[hs_adr];
    end

    always @(posedge clk) begin
        if (buf_we) bufm[buf_ad] <= buf_wd;
        else if (bd_bwe) bufm[bd_badr] <= bd_bdat;
        buf_rd <= bufm[buf_ad];
    end

    task automatic step();
        @(negedge clk);
        if (hs_wr) begin
            wr_cnt++;
            obs_hs.push_back({hs_adr, hs_din});
        end
        if (buf_we) begin
            we_cnt++;
            obs_buf.push_back({8'h00, buf_ad, buf_wd});
        end
        if ((hs_wr && buf_we) || ((hs_wr || buf_we) && !hs_acc)) viol++;
        if (done) done_cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic ram_wr(input logic [15:0] a, input logic [7:0] d);
        bd_rwe = 1'b1; bd_radr = a; bd_rdat = d;
        step();
        bd_rwe = 1'b0;
    endtask

    task automatic buf_wr(input logic [7:0] a, input logic [7:0] d);
        bd_bwe = 1'b1; bd_badr = a; bd_bdat = d;
        step();
        bd_bwe = 1'b0;
    endtask

    task automatic pulse_req(input logic r, input logic d);
        rreq = r; dreq = d;
        step();
        rreq = 1'b0; dreq = 1'b0;
    endtask

    task automatic frame();
        vblk = 1'b1;
        step();
        vblk = 1'b0;
        steps(9);
    endtask

    task automatic run_to_done(input int budget, output int cyc);
        cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            step();
            if (done) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vblk = 1'b0; rreq = 1'b0; dreq = 1'b0;
        bd_rwe = 1'b0; bd_bwe = 1'b0;
        bd_radr = '0; bd_rdat = '0; bd_badr = '0; bd_bdat = '0;
        steps(3);
        total++;
        if ({hs_acc, hs_wr, buf_we, pause, busy, done, err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {hs_acc, hs_wr, buf_we, pause, busy, done, err});
        end
        total++;
        if ({hs_adr, hs_din, buf_ad, buf_wd} !== 40'h0) begin
            bad++;
            $display("FAIL reset_buses got=%h exp=0", {hs_adr, hs_din, buf_ad, buf_wd});
        end
        rst_n = 1'b1;
        steps(2);
    endtask

    task automatic test_dump();
        int cyc, nbad;
        logic [23:0] e, o;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            ram_wr(16'hE000 + 16'(i), b ^ 8'h5A);
        end
        exp_q.delete(); obs_buf.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            exp_q.push_back({8'h00, b, b ^ 8'h5A});
        end
        pulse_req(1'b0, 1'b1);
        total++;
        if ({busy, hs_acc, pause} !== 3'b111) begin
            bad++;
            $display("FAIL dump_start got=%b exp=111", {busy, hs_acc, pause});
        end
        run_to_done(400, cyc);
        total++;
        if (cyc + 1 != 130) begin
            bad++;
            $display("FAIL dump_latency got=%0d exp=130", cyc + 1);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL dump_err got=%b exp=0", err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_buf.size() > 0) ? obs_buf.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dump_buf_wr got=%h exp=%h", o, e);
            end
        end
        step();
        nbad = 0;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            if (bufm[b] !== (b ^ 8'h5A)) nbad++;
        end
        total++;
        if (nbad != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL dump_contents got=%0d/%b exp=0/0", nbad, busy);
        end
    endtask

    task automatic test_restore();
        int acc_at, done_at, nbad, w0;
        logic [23:0] e, o;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            buf_wr(b, b);
            ram_wr(16'hE000 + 16'(i), (i == 0 || i == 63) ? 8'h00 : 8'hFF);
        end
        exp_q.delete(); obs_hs.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            exp_q.push_back({16'hE000 + 16'(i), b});
        end
        w0 = wr_cnt;
        pulse_req(1'b1, 1'b0);
        steps(4);
        total++;
        if ({busy, hs_acc, pause} !== 3'b100 || wr_cnt != w0) begin
            bad++;
            $display("FAIL restore_waitv got=%b/%0d exp=100/0",
                     {busy, hs_acc, pause}, wr_cnt - w0);
        end
        vblk = 1'b1;
        acc_at = -1; done_at = -1;
        for (int k = 1; k <= 400; k++) begin
            step();
            if (k == 3) vblk = 1'b0;
            if (hs_acc && acc_at < 0) acc_at = k;
            if (done) begin
                done_at = k;
                break;
            end
        end
        vblk = 1'b0;
        total++;
        if (acc_at < 0 || done_at - acc_at != 133) begin
            bad++;
            $display("FAIL restore_latency got=%0d exp=133", done_at - acc_at);
        end
        step();
        total++;
        if ({pause, busy, hs_acc, err} !== 4'b0) begin
            bad++;
            $display("FAIL restore_end got=%b exp=0000", {pause, busy, hs_acc, err});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_hs.size() > 0) ? obs_hs.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL restore_ram_wr got=%h exp=%h", o, e);
            end
        end
        nbad = 0;
        for (int i = 0; i < 64; i++)
            if (ram[16'hE000 + 16'(i)] !== 8'(i)) nbad++;
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL restore_contents got=%0d exp=0", nbad);
        end
    endtask

    task automatic test_retry();
        int cyc, w0, d0;
        logic [23:0] e, o;
        logic [7:0] b;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            buf_wr(b, ~b);
        end
        ram_wr(16'hE000, 8'hFF);
        ram_wr(16'hE03F, 8'h00);
        exp_q.delete(); obs_hs.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            exp_q.push_back({16'hE000 + 16'(i), ~b});
        end
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req(1'b1, 1'b0);
        for (int f = 0; f < 3; f++) frame();
        total++;
        if (wr_cnt != w0 || busy !== 1'b1 || done_cnt != d0) begin
            bad++;
            $display("FAIL retry_hold got=%0d/%b/%0d exp=0/1/0",
                     wr_cnt - w0, busy, done_cnt - d0);
        end
        ram_wr(16'hE000, 8'h00);
        vblk = 1'b1;
        step();
        vblk = 1'b0;
        run_to_done(300, cyc);
        total++;
        if (cyc != 133 || err !== 1'b0) begin
            bad++;
            $display("FAIL retry_frame4 got=%0d/%b exp=133/0", cyc, err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_hs.size() > 0) ? obs_hs.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL retry_ram_wr got=%h exp=%h", o, e);
            end
        end
        steps(2);
    endtask

    task automatic test_timeout();
        int cyc, w0, d0;
        ram_wr(16'hE000, 8'hFF);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req(1'b1, 1'b0);
        for (int f = 0; f < 239; f++) frame();
        total++;
        if (err !== 1'b0 || busy !== 1'b1 || done_cnt != d0) begin
            bad++;
            $display("FAIL timeout_early got=%b/%b/%0d exp=0/1/0",
                     err, busy, done_cnt - d0);
        end
        vblk = 1'b1;
        step();
        vblk = 1'b0;
        run_to_done(40, cyc);
        total++;
        if (cyc != 5 || err !== 1'b1 || wr_cnt != w0) begin
            bad++;
            $display("FAIL timeout_err got=%0d/%b/%0d exp=5/1/0",
                     cyc, err, wr_cnt - w0);
        end
        steps(3);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_sticky got=%b/%b exp=1/0", err, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, we0;
        logic [23:0] e, o;
        logic [7:0] b;
        ram_wr(16'hE000, 8'h00);
        ram_wr(16'hE03F, 8'h00);
        exp_q.delete(); obs_hs.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            exp_q.push_back({16'hE000 + 16'(i), ~b});
        end
        we0 = we_cnt;
        pulse_req(1'b1, 1'b1);
        steps(2);
        total++;
        if ({busy, hs_acc, err} !== 3'b100) begin
            bad++;
            $display("FAIL collide_restore got=%b exp=100", {busy, hs_acc, err});
        end
        pulse_req(1'b0, 1'b1);
        steps(3);
        total++;
        if ({busy, hs_acc} !== 2'b10) begin
            bad++;
            $display("FAIL busy_dump_ignored got=%b exp=10", {busy, hs_acc});
        end
        vblk = 1'b1;
        step();
        vblk = 1'b0;
        steps(20);
        pulse_req(1'b0, 1'b1);
        run_to_done(300, cyc);
        total++;
        if (cyc != 112 || we_cnt != we0) begin
            bad++;
            $display("FAIL collide_done got=%0d/%0d exp=112/0", cyc, we_cnt - we0);
        end
        steps(3);
        total++;
        if (busy !== 1'b0 || we_cnt != we0) begin
            bad++;
            $display("FAIL dump_not_queued got=%b/%0d exp=0/0", busy, we_cnt - we0);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_hs.size() > 0) ? obs_hs.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL collide_ram_wr got=%h exp=%h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, w0, d0, nbad;
        bit found;
        logic [23:0] e, o;
        logic [7:0] b, x;
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            buf_wr(b, b ^ 8'hC3);
            ram_wr(16'hE000 + 16'(i), (i == 0 || i == 63) ? 8'h00 : 8'h11);
        end
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req(1'b1, 1'b0);
        step();
        vblk = 1'b1;
        step();
        vblk = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            step();
            if (hs_acc && !hs_wr && buf_ad == 8'd10) begin
                found = 1'b1;
                break;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (!found || {hs_acc, hs_wr, buf_we, pause, busy, done, err} !== 7'b0) begin
            bad++;
            $display("FAIL async_reset_flags got=%b/%b exp=1/0000000", found,
                     {hs_acc, hs_wr, buf_we, pause, busy, done, err});
        end
        total++;
        if ({hs_adr, hs_din, buf_ad, buf_wd} !== 40'h0) begin
            bad++;
            $display("FAIL async_reset_buses got=%h exp=0", {hs_adr, hs_din, buf_ad, buf_wd});
        end
        steps(4);
        rst_n = 1'b1;
        steps(4);
        total++;
        if (done_cnt != d0 || wr_cnt - w0 != 10) begin
            bad++;
            $display("FAIL abort_writes got=%0d/%0d exp=0/10", done_cnt - d0, wr_cnt - w0);
        end
        nbad = 0;
        exp_q.delete(); obs_buf.delete();
        for (int i = 0; i < 64; i++) begin
            b = 8'(i);
            x = (i < 10) ? (b ^ 8'hC3) : ((i == 63) ? 8'h00 : 8'h11);
            if (ram[16'hE000 + 16'(i)] !== x) nbad++;
            exp_q.push_back({8'h00, b, x});
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL abort_ram got=%0d exp=0", nbad);
        end
        pulse_req(1'b0, 1'b1);
        run_to_done(400, cyc);
        total++;
        if (cyc + 1 != 130 || err !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_dump got=%0d/%b exp=130/0", cyc + 1, err);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_buf.size() > 0) ? obs_buf.pop_front() : 24'hxxxxxx;
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset_buf_wr got=%h exp=%h", o, e);
            end
        end
        steps(2);
    endtask

    initial begin
        test_reset();
        test_dump();
        test_restore();
        test_retry();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL write_exclusion got=%0d exp=0", viol);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
